// File: rtl/pipeline4.sv
// pipeline4: memory-access / write-back stage sitting directly behind execute.
// Define MEM_TIMEOUT_EN to bound the wait for mem_ack with an 8-bit counter (MEM_TIMEOUT cycles).
module pipeline4 #(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned MEM_WIDTH      = 16,
  parameter int unsigned PC_WIDTH       = 16,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned CTRL_WIDTH     = 6,
  parameter int unsigned MEM_TIMEOUT    = 15,
  // Opcode encodings; must match the shared params_proc.v table.
  parameter logic [CTRL_WIDTH-1:0] OP_NOP  = CTRL_WIDTH'(0),
  parameter logic [CTRL_WIDTH-1:0] OP_LW   = CTRL_WIDTH'(16),
  parameter logic [CTRL_WIDTH-1:0] OP_SW   = CTRL_WIDTH'(17),
  parameter logic [CTRL_WIDTH-1:0] OP_JR   = CTRL_WIDTH'(24),
  parameter logic [CTRL_WIDTH-1:0] OP_JPC  = CTRL_WIDTH'(25),
  parameter logic [CTRL_WIDTH-1:0] OP_BRFL = CTRL_WIDTH'(26),
  parameter logic [CTRL_WIDTH-1:0] OP_RET  = CTRL_WIDTH'(27)
) (
  input  logic                      clk_in,
  input  logic                      RST,
  input  logic [CTRL_WIDTH-1:0]     ctrl_in,
  input  logic                      pc_chg_in,
  input  logic [PC_WIDTH-1:0]       pc_in,
  input  logic                      mem_we_in,
  input  logic [DATA_WIDTH-1:0]     data_in,
  input  logic [MEM_WIDTH-1:0]      addr_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr_in,
  output logic                      mem_req,
  output logic                      mem_wr,
  output logic [MEM_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ack,
  output logic                      reg_we,
  output logic [REG_ADDR_WIDTH-1:0] reg_waddr,
  output logic [DATA_WIDTH-1:0]     reg_wdata,
  output logic                      pc_chg,
  output logic [PC_WIDTH-1:0]       pc_out,
  output logic                      stall
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
    $error("pipeline4: MEM_TIMEOUT must fit the 8-bit counter (1..255)");
  end

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait} state_e;

  state_e                    r_state, w_state_next;
  logic                      r_mem_req, w_mem_req_next;
  logic                      r_mem_wr, w_mem_wr_next;
  logic [MEM_WIDTH-1:0]      r_mem_addr, w_mem_addr_next;
  logic [DATA_WIDTH-1:0]     r_mem_wdata, w_mem_wdata_next;
  logic                      r_reg_we, w_reg_we_next;
  logic [REG_ADDR_WIDTH-1:0] r_reg_waddr, w_reg_waddr_next;
  logic [DATA_WIDTH-1:0]     r_reg_wdata, w_reg_wdata_next;
  logic                      r_pc_chg, w_pc_chg_next;
  logic [PC_WIDTH-1:0]       r_pc_out, w_pc_out_next;
  logic [REG_ADDR_WIDTH-1:0] r_ld_waddr, w_ld_waddr_next;

  logic w_is_lw, w_is_sw, w_no_wb, w_timeout;

  assign w_is_lw = (ctrl_in == OP_LW);
  assign w_is_sw = (ctrl_in == OP_SW) || mem_we_in;
  assign w_no_wb = ctrl_in inside {OP_SW, OP_JR, OP_JPC, OP_BRFL, OP_RET, OP_NOP};

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_to_cnt;

  // Cleared while idle, so it is zero on the first wait cycle of every access.
  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_to_cnt <= '0;
    end else if (r_state == StIdle) begin
      r_to_cnt <= '0;
    end else if (!mem_ack) begin
      r_to_cnt <= r_to_cnt + 8'd1;
    end
  end

  assign w_timeout = !mem_ack && (r_to_cnt == 8'(MEM_TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_next     = r_state;
    w_mem_req_next   = r_mem_req;
    w_mem_wr_next    = r_mem_wr;
    w_mem_addr_next  = r_mem_addr;
    w_mem_wdata_next = r_mem_wdata;
    w_reg_we_next    = 1'b0;
    w_reg_waddr_next = r_reg_waddr;
    w_reg_wdata_next = r_reg_wdata;
    w_pc_chg_next    = 1'b0;
    w_pc_out_next    = r_pc_out;
    w_ld_waddr_next  = r_ld_waddr;
    case (r_state)
      StIdle: begin
        if (w_is_lw) begin
          w_mem_req_next  = 1'b1;
          w_mem_wr_next   = 1'b0;
          w_mem_addr_next = addr_in;
          w_ld_waddr_next = reg_addr_in;
          w_state_next    = StRdWait;
        end else if (w_is_sw) begin
          w_mem_req_next   = 1'b1;
          w_mem_wr_next    = 1'b1;
          w_mem_addr_next  = addr_in;
          w_mem_wdata_next = data_in;
          w_state_next     = StWrWait;
        end else begin
          w_pc_chg_next    = pc_chg_in;
          w_pc_out_next    = pc_in;
          w_reg_waddr_next = reg_addr_in;
          w_reg_wdata_next = data_in;
          w_reg_we_next    = !w_no_wb;
        end
      end
      StRdWait: begin
        // A timed-out load still retires, writing zero to its destination.
        if (mem_ack || w_timeout) begin
          w_mem_req_next   = 1'b0;
          w_reg_we_next    = 1'b1;
          w_reg_waddr_next = r_ld_waddr;
          w_reg_wdata_next = mem_ack ? mem_rdata : '0;
          w_state_next     = StIdle;
        end
      end
      StWrWait: begin
        if (mem_ack || w_timeout) begin
          w_mem_req_next = 1'b0;
          w_state_next   = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_state     <= StIdle;
      r_mem_req   <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_reg_we    <= 1'b0;
      r_reg_waddr <= '0;
      r_reg_wdata <= '0;
      r_pc_chg    <= 1'b0;
      r_pc_out    <= '0;
      r_ld_waddr  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_mem_req   <= w_mem_req_next;
      r_mem_wr    <= w_mem_wr_next;
      r_mem_addr  <= w_mem_addr_next;
      r_mem_wdata <= w_mem_wdata_next;
      r_reg_we    <= w_reg_we_next;
      r_reg_waddr <= w_reg_waddr_next;
      r_reg_wdata <= w_reg_wdata_next;
      r_pc_chg    <= w_pc_chg_next;
      r_pc_out    <= w_pc_out_next;
      r_ld_waddr  <= w_ld_waddr_next;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_wr    = r_mem_wr;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign reg_we    = r_reg_we;
  assign reg_waddr = r_reg_waddr;
  assign reg_wdata = r_reg_wdata;
  assign pc_chg    = r_pc_chg;
  assign pc_out    = r_pc_out;
  assign stall     = (r_state != StIdle);

endmodule

// File: tb/tb_pipeline4.sv
// Self-checking bench for pipeline4: vector table plus scoreboard queues for
// register writes, PC redirects and memory requests.
module tb_pipeline4;
  localparam logic [5:0] OP_NOP = 6'd0, OP_ADD = 6'd1, OP_SUB = 6'd2, OP_LW = 6'd16;
  localparam logic [5:0] OP_SW = 6'd17, OP_JR = 6'd24, OP_JPC = 6'd25, OP_BRFL = 6'd26;
  localparam logic [5:0] OP_RET = 6'd27;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ctrl;
  logic        pchg_in, mem_we_in, mem_ack;
  logic [15:0] pc_in, data_in, addr_in, mem_rdata;
  logic [3:0]  raddr_in;
  logic        mem_req, mem_wr, reg_we, pc_chg, stall;
  logic [15:0] mem_addr, mem_wdata, reg_wdata, pc_out;
  logic [3:0]  reg_waddr;

  always #5 clk = ~clk;

  pipeline4 #(.MEM_TIMEOUT(4)) u_dut (
    .clk_in(clk), .RST(rst), .ctrl_in(ctrl), .pc_chg_in(pchg_in), .pc_in(pc_in),
    .mem_we_in(mem_we_in), .data_in(data_in), .addr_in(addr_in), .reg_addr_in(raddr_in),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .reg_we(reg_we), .reg_waddr(reg_waddr),
    .reg_wdata(reg_wdata), .pc_chg(pc_chg), .pc_out(pc_out), .stall(stall)
  );

  typedef struct {logic [3:0] waddr; logic [15:0] wdata;} reg_ev_t;
  typedef struct {logic wr; logic [15:0] addr; logic [15:0] wdata;} mem_ev_t;
  typedef struct {
    string name; logic [5:0] ctrl; logic pchg; logic [15:0] pc; logic we_in;
    logic [15:0] data; logic [15:0] addr; logic [3:0] raddr; int ack_dly; logic [15:0] rdata;
    logic x_req; logic x_wr; logic x_we; logic [15:0] x_wdata; logic x_pchg;
  } vec_t;

  reg_ev_t     reg_q[$];
  logic [15:0] pc_q[$];
  mem_ev_t     mem_q[$];
  mem_ev_t     cur_mem;
  logic        prev_req = 1'b0;
  int          checks = 0, failures = 0;
  vec_t        vecs[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Pops scoreboard entries whenever the DUT produces an event.
  task automatic mon();
    if (reg_we) begin
      if (reg_q.size() == 0) chk("unexpected reg_we", 1, 0);
      else begin
        reg_ev_t e;
        e = reg_q.pop_front();
        chk("reg_waddr", 32'(reg_waddr), 32'(e.waddr));
        chk("reg_wdata", 32'(reg_wdata), 32'(e.wdata));
      end
    end
    if (pc_chg) begin
      if (pc_q.size() == 0) chk("unexpected pc_chg", 1, 0);
      else chk("pc_out", 32'(pc_out), 32'(pc_q.pop_front()));
    end
    if (mem_req && !prev_req) begin
      if (mem_q.size() == 0) chk("unexpected mem_req", 1, 0);
      else cur_mem = mem_q.pop_front();
    end
    if (mem_req) begin
      chk("mem_wr", 32'(mem_wr), 32'(cur_mem.wr));
      chk("mem_addr", 32'(mem_addr), 32'(cur_mem.addr));
      if (cur_mem.wr) chk("mem_wdata", 32'(mem_wdata), 32'(cur_mem.wdata));
    end
    prev_req = mem_req;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic apply(input vec_t v);
    ctrl = v.ctrl; pchg_in = v.pchg; pc_in = v.pc; mem_we_in = v.we_in;
    data_in = v.data; addr_in = v.addr; raddr_in = v.raddr;
    if (v.x_req) mem_q.push_back('{v.x_wr, v.addr, v.data});
    if (v.x_we) reg_q.push_back('{v.raddr, v.x_wdata});
    if (v.x_pchg) pc_q.push_back(v.pc);
    tick();
    if (v.x_req) begin
      chk({v.name, " issue mem_req"}, 32'(mem_req), 1);
      chk({v.name, " issue stall"}, 32'(stall), 1);
      for (int k = 1; k < v.ack_dly; k++) begin
        tick();
        chk({v.name, " wait mem_req"}, 32'(mem_req), 1);
        chk({v.name, " wait stall"}, 32'(stall), 1);
      end
      mem_ack = 1'b1; mem_rdata = v.rdata;
      tick();
      mem_ack = 1'b0; mem_rdata = 16'h0BAD;
      chk({v.name, " done mem_req"}, 32'(mem_req), 0);
    end
    chk({v.name, " stall"}, 32'(stall), 0);
    chk({v.name, " reg_we"}, 32'(reg_we), 32'(v.x_we));
    chk({v.name, " pc_chg"}, 32'(pc_chg), 32'(v.x_pchg));
  endtask

  task automatic idle_inputs();
    ctrl = OP_NOP; pchg_in = 1'b0; pc_in = '0; mem_we_in = 1'b0;
    data_in = '0; addr_in = '0; raddr_in = '0;
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic timeout_case(input logic wr);
    int n;
    ctrl = wr ? OP_SW : OP_LW; addr_in = 16'h0077; data_in = 16'h7777; raddr_in = 4'd9;
    mem_q.push_back('{wr, 16'h0077, 16'h7777});
    if (!wr) reg_q.push_back('{4'd9, 16'h0000});
    tick();
    n = 0;
    while (mem_req && n < 20) begin
      n++;
      tick();
    end
    idle_inputs();
    chk(wr ? "sw timeout cycles" : "lw timeout cycles", 32'(n), 4);
    chk(wr ? "sw timeout reg_we" : "lw timeout reg_we", 32'(reg_we), 32'(!wr));
    chk("timeout stall", 32'(stall), 0);
  endtask
`endif

  initial begin
    //         name        ctrl     pchg  pc        we    data      addr      ra    dly rdata
    //         req   wr    we    wdata     pchg
    vecs[0]  = '{"add",      OP_ADD,  1'b0, 16'h0000, 1'b0, 16'h0012, 16'h0000, 4'd3,  0, 16'h0,
                 1'b0, 1'b0, 1'b1, 16'h0012, 1'b0};
    vecs[1]  = '{"sub",      OP_SUB,  1'b0, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 4'd15, 0, 16'h0,
                 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0};
    vecs[2]  = '{"lw",       OP_LW,   1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0040, 4'd5,  3, 16'hBEEF,
                 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0};
    vecs[3]  = '{"sw",       OP_SW,   1'b0, 16'h0000, 1'b0, 16'h1234, 16'h0010, 4'd2,  1, 16'h0,
                 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[4]  = '{"jr",       OP_JR,   1'b1, 16'h0020, 1'b0, 16'h0009, 16'h0000, 4'd1,  0, 16'h0,
                 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[5]  = '{"nop",      OP_NOP,  1'b0, 16'h0000, 1'b0, 16'h5555, 16'h0000, 4'd6,  0, 16'h0,
                 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[6]  = '{"jpc",      OP_JPC,  1'b1, 16'hABCD, 1'b0, 16'h0000, 16'h0000, 4'd0,  0, 16'h0,
                 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[7]  = '{"brfl",     OP_BRFL, 1'b0, 16'h0044, 1'b0, 16'h0007, 16'h0000, 4'd2,  0, 16'h0,
                 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
    vecs[8]  = '{"ret",      OP_RET,  1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000, 4'd4,  0, 16'h0,
                 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
    vecs[9]  = '{"lw_b2b_a", OP_LW,   1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0041, 4'd7,  1, 16'h5A5A,
                 1'b1, 1'b0, 1'b1, 16'h5A5A, 1'b0};
    vecs[10] = '{"lw_b2b_b", OP_LW,   1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0042, 4'd8,  2, 16'h0001,
                 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0};
    vecs[11] = '{"mem_we",   OP_ADD,  1'b0, 16'h0000, 1'b1, 16'hC0DE, 16'h0033, 4'd4,  2, 16'h0,
                 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[12] = '{"lw_pchg",  OP_LW,   1'b1, 16'h0FF0, 1'b0, 16'h0000, 16'h0050, 4'd10, 1, 16'h8001,
                 1'b1, 1'b0, 1'b1, 16'h8001, 1'b0};
    vecs[13] = '{"add_pchg", OP_ADD,  1'b1, 16'h0200, 1'b0, 16'h0077, 16'h0000, 4'd11, 0, 16'h0,
                 1'b0, 1'b0, 1'b1, 16'h0077, 1'b1};
    vecs[14] = '{"sw_long",  OP_SW,   1'b0, 16'h0000, 1'b0, 16'hFACE, 16'h0060, 4'd0,  4, 16'h0,
                 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
    vecs[15] = '{"add_r0",   OP_ADD,  1'b0, 16'h0000, 1'b0, 16'hA5A5, 16'h0000, 4'd0,  0, 16'h0,
                 1'b0, 1'b0, 1'b1, 16'hA5A5, 1'b0};

    // Reset with random inputs on every port.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ctrl = 6'($urandom); pchg_in = 1'($urandom); pc_in = 16'($urandom);
      mem_we_in = 1'($urandom); data_in = 16'($urandom); addr_in = 16'($urandom);
      raddr_in = 4'($urandom); mem_ack = 1'($urandom); mem_rdata = 16'($urandom);
      tick();
    end
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst mem_wr", 32'(mem_wr), 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst mem_wdata", 32'(mem_wdata), 0);
    chk("rst reg_we", 32'(reg_we), 0);
    chk("rst reg_waddr", 32'(reg_waddr), 0);
    chk("rst reg_wdata", 32'(reg_wdata), 0);
    chk("rst pc_chg", 32'(pc_chg), 0);
    chk("rst pc_out", 32'(pc_out), 0);
    chk("rst stall", 32'(stall), 0);
    idle_inputs();
    mem_ack = 1'b0; mem_rdata = 16'h0BAD;
    rst = 1'b0;

    for (int i = 0; i < 16; i++) apply(vecs[i]);
    idle_inputs();
    tick();

    // Reset while a load waits: the request is abandoned and nothing is written.
    ctrl = OP_LW; addr_in = 16'h0090; raddr_in = 4'd12;
    mem_q.push_back('{1'b0, 16'h0090, 16'h0000});
    tick();
    chk("rst_mid issue mem_req", 32'(mem_req), 1);
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid mem_req", 32'(mem_req), 0);
    chk("rst_mid stall", 32'(stall), 0);
    chk("rst_mid reg_we", 32'(reg_we), 0);
    rst = 1'b0;
    idle_inputs();

    // Ack arriving while idle is ignored.
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    tick();
    chk("idle_ack mem_req", 32'(mem_req), 0);
    chk("idle_ack reg_we", 32'(reg_we), 0);
    chk("idle_ack stall", 32'(stall), 0);
    mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
    timeout_case(1'b0);
    timeout_case(1'b1);
`endif

    tick();
    tick();
    chk("reg queue drained", 32'(reg_q.size()), 0);
    chk("pc queue drained", 32'(pc_q.size()), 0);
    chk("mem queue drained", 32'(mem_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipeline4.md
Name: pipeline4

Overview:
- Memory-access / write-back stage of the processor pipeline, directly downstream of the execute stage.
- Consumes the execute stage's registered outputs: ctrl, pc_chg, pc, mem_we, data, addr and reg_addr.
- Performs LW/SW through a req/ack data-memory handshake and stalls the pipeline while an access is outstanding.
- Produces the register-file write port and forwards the PC redirect to fetch.

Parameters:
DATA_WIDTH, 16, register/data word width
MEM_WIDTH, 16, data-memory address width
PC_WIDTH, 16, program counter width
REG_ADDR_WIDTH, 4, register address width
CTRL_WIDTH, 6, control/opcode width; opcode values come from the shared params_proc.v include
MEM_TIMEOUT, 15, max wait cycles for mem_ack (used only with MEM_TIMEOUT_EN)

Ports:
clk_in  in  1  clock, all logic on posedge
RST  in  1  synchronous reset, active-high
ctrl_in  in  CTRL_WIDTH  opcode from execute stage
pc_chg_in  in  1  PC redirect request from execute stage
pc_in  in  PC_WIDTH  redirect target
mem_we_in  in  1  store indication (SW)
data_in  in  DATA_WIDTH  ALU result or store data
addr_in  in  MEM_WIDTH  computed memory address
reg_addr_in  in  REG_ADDR_WIDTH  destination register
mem_req  out  1  memory request, held until ack
mem_wr  out  1  1 = write, 0 = read
mem_addr  out  MEM_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  store data
mem_rdata  in  DATA_WIDTH  load data, valid with mem_ack
mem_ack  in  1  access complete
reg_we  out  1  register write enable, one-cycle pulse
reg_waddr  out  REG_ADDR_WIDTH  register write address
reg_wdata  out  DATA_WIDTH  register write data
pc_chg  out  1  redirect to fetch, one-cycle pulse
pc_out  out  PC_WIDTH  redirect target
stall  out  1  combinational; 1 whenever state != IDLE

Behaviour:
- One clock (clk_in). Reset RST is synchronous and active-high.
- Reset: state=IDLE. All outputs are 0: mem_req, mem_wr, mem_addr, mem_wdata, reg_we, reg_waddr, reg_wdata, pc_chg, pc_out. The timeout counter is 0.
- Reset mid-access drops mem_req on the next edge and abandons the access. No reg write occurs.
- States: IDLE, RD_WAIT, WR_WAIT.
- Inputs are sampled only in IDLE. While stall=1 the upstream controller holds the inputs stable, and they are ignored.
- reg_we and pc_chg default to 0 on every edge, so they are single-cycle pulses.
- IDLE, ctrl_in==LW:
  - Next edge: mem_req=1, mem_wr=0, mem_addr=addr_in.
  - reg_addr_in is latched; state goes to RD_WAIT.
- IDLE, ctrl_in==SW (or mem_we_in=1):
  - Next edge: mem_req=1, mem_wr=1, mem_addr=addr_in, mem_wdata=data_in.
  - State goes to WR_WAIT.
- IDLE, any other opcode: 1-cycle latency.
  - pc_chg=pc_chg_in, pc_out=pc_in.
  - reg_waddr=reg_addr_in, reg_wdata=data_in.
  - reg_we=1 except for SW, JR, JPC, BRFL, RET and NOP. NOP writes nothing.
- RD_WAIT, mem_ack=1:
  - Next edge: mem_req=0, reg_we=1, reg_waddr=latched addr, reg_wdata=mem_rdata.
  - State goes to IDLE.
- WR_WAIT, mem_ack=1: next edge mem_req=0, state goes to IDLE, no reg write.
- mem_ack is only examined in the WAIT states; ack in IDLE is ignored. Minimum load/store latency is 2 cycles (request edge, then ack edge).
- mem_addr, mem_wr and mem_wdata stay stable while mem_req=1.
- LW and SW never assert pc_chg.
- Back-to-back loads: the held instruction is sampled on the first IDLE cycle after completion, with no bubble beyond the stall.

Optional Feature:
MEM_TIMEOUT_EN
- Defined: an 8-bit counter clears on request issue and increments each WAIT cycle without ack.
  - On reaching MEM_TIMEOUT: mem_req drops and state goes to IDLE.
  - A timed-out load writes 0 to its destination register (reg_we pulses). A timed-out store is dropped.
- Undefined: there is no counter and the block waits indefinitely for mem_ack.

Test Plan:
- Reset: hold RST=1 for 2 cycles with random inputs -> all outputs 0, stall=0.
- ALU op: ctrl_in=ADD, data_in=0x0012, reg_addr_in=3 -> reg_we pulse 1 cycle later, reg_waddr=3, reg_wdata=0x0012, stall stays 0.
- Load: LW, addr_in=0x0040, reg_addr_in=5; ack after 3 cycles with mem_rdata=0xBEEF -> mem_req held 3 cycles at 0x0040, stall=1 throughout, then reg_we with r5=0xBEEF, stall=0.
- Store: SW, addr_in=0x0010, data_in=0x1234; immediate ack -> one cycle with mem_req=1, mem_wr=1, mem_wdata=0x1234; no reg_we.
- Redirect: JR, pc_chg_in=1, pc_in=0x0020 -> pc_chg pulse, pc_out=0x0020, reg_we=0. Reset asserted during RD_WAIT -> mem_req=0 next edge, no write.
- MEM_TIMEOUT_EN, MEM_TIMEOUT=4: LW with no ack -> mem_req drops after 4 wait cycles, reg_we with reg_wdata=0.
